// File: rtl/buffer_ctrl_pkg.sv
// Shared types and helpers for the circular-buffer controller.
package buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Working width for wrap_add; wide enough for any practical buffer depth.
  localparam int unsigned WRAP_W = 16;

  // Modulo-mem_size pointer advance: add, then subtract once if the sum wrapped.
  function automatic logic [WRAP_W-1:0] wrap_add(
    input logic [WRAP_W-1:0] ptr,
    input logic [WRAP_W-1:0] inc,
    input logic [WRAP_W-1:0] mem_size
  );
    logic [WRAP_W-1:0] sum;
    sum = ptr + inc;
    if (sum >= mem_size) begin
      sum = sum - mem_size;
    end
    return sum;
  endfunction

endpackage

// File: rtl/buffer_ctrl_circ_ptr.sv
// Circular pointer that advances by a fixed INC modulo MEM_SIZE.
module circ_ptr
  import buffer_ctrl_pkg::*;
#(
  parameter  int unsigned MEM_SIZE = 4,
  parameter  int unsigned INC      = 1,
  localparam int unsigned ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ADDR_W'(wrap_add(WRAP_W'(ptr_q), WRAP_W'(INC), WRAP_W'(MEM_SIZE)));
  end

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Handshake, occupancy and end-of-stream control for a parallel-write / sliding-window-read circular buffer.
module buffer_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter  int unsigned MEM_SIZE  = 4,
  parameter  int unsigned PAR_WRITE = 2,
  parameter  int unsigned PAR_READ  = 3,
  parameter  int unsigned STRIDE    = 1,
  localparam int unsigned ADDR_W    = $clog2(MEM_SIZE),
  localparam int unsigned CNT_W     = $clog2(MEM_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              flush,
  output logic              buf_wen,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [ADDR_W-1:0] buf_raddr,
  output logic [CNT_W-1:0]  count,
  output logic              done
);

  localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(MEM_SIZE - PAR_WRITE);
  localparam logic [CNT_W-1:0] RD_MIN   = CNT_W'(PAR_READ);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_q;
  logic             push;
  logic             pop;
  logic             ptr_clr;

  // Handshake and occupancy; a flush cycle suppresses both transfers.
  always_comb begin
    wr_ready = rst && ((state_q == S_FILL) || (state_q == S_STREAM)) && (count_q <= WR_LIMIT);
    rd_valid = rst && ((state_q == S_STREAM) || (state_q == S_DRAIN)) && (count_q >= RD_MIN);
    push     = wr_valid && wr_ready && !flush;
    pop      = rd_valid && rd_ready && !flush;
    buf_wen  = push;
    ptr_clr  = flush || (state_q == S_DONE);
    count_d  = count_q;
    if (push) begin
      count_d = count_d + CNT_W'(PAR_WRITE);
    end
    if (pop) begin
      count_d = count_d - CNT_W'(STRIDE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (push && wr_last) begin
          state_d = S_DRAIN;
        end else if (count_d >= RD_MIN) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (push && wr_last) begin
          state_d = S_DRAIN;
        end
      end
      // Leftover elements shorter than a window are dropped here.
      S_DRAIN: begin
        if (count_q < RD_MIN) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q <= S_FILL;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= (state_q == S_DONE) ? '0 : count_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  circ_ptr #(
    .MEM_SIZE (MEM_SIZE),
    .INC      (PAR_WRITE)
  ) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ptr_clr),
    .adv_i (push),
    .ptr_o (buf_waddr)
  );

  circ_ptr #(
    .MEM_SIZE (MEM_SIZE),
    .INC      (STRIDE)
  ) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ptr_clr),
    .adv_i (pop),
    .ptr_o (buf_raddr)
  );

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl: default 4-deep instance plus a 6-deep instance for wrap and flush cases.
module tb_buffer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_valid, wr_last, rd_ready, flush;
  logic       wr_ready, rd_valid, buf_wen, done;
  logic [1:0] buf_waddr, buf_raddr;
  logic [2:0] count;

  logic       v6, l6, rr6, f6;
  logic       wrr6, rv6, wen6, done6;
  logic [2:0] wa6, ra6;
  logic [2:0] c6;

  int checks   = 0;
  int failures = 0;

  buffer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .flush     (flush),
    .buf_wen   (buf_wen),
    .buf_waddr (buf_waddr),
    .buf_raddr (buf_raddr),
    .count     (count),
    .done      (done)
  );

  buffer_ctrl #(.MEM_SIZE(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (v6),
    .wr_last   (l6),
    .wr_ready  (wrr6),
    .rd_valid  (rv6),
    .rd_ready  (rr6),
    .flush     (f6),
    .buf_wen   (wen6),
    .buf_waddr (wa6),
    .buf_raddr (ra6),
    .count     (c6),
    .done      (done6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    v6 = 1'b0; l6 = 1'b0; rr6 = 1'b0; f6 = 1'b0;

    // Reset held for two edges
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      check("rst_count", 32'(count), 0);
      check("rst_waddr", 32'(buf_waddr), 0);
      check("rst_raddr", 32'(buf_raddr), 0);
      check("rst_wen", 32'(buf_wen), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_wr_ready", 32'(wr_ready), 0);
      check("rst_done", 32'(done), 0);
      check("rst_count6", 32'(c6), 0);
    end
    wr_valid = 1'b1; #1;
    check("rst_wen_gated", 32'(buf_wen), 0);
    wr_valid = 1'b0;
    rst = 1'b1; #1;
    check("rel_wr_ready", 32'(wr_ready), 1);
    check("rel_rd_valid", 32'(rd_valid), 0);

    // Two pushes fill the 4-deep buffer
    wr_valid = 1'b1; #1;
    check("p1_wen", 32'(buf_wen), 1);
    check("p1_waddr", 32'(buf_waddr), 0);
    tick(); #2;
    check("p1_count", 32'(count), 2);
    check("p1_waddr_after", 32'(buf_waddr), 2);
    check("p1_rd_valid", 32'(rd_valid), 0);
    check("p1_wr_ready", 32'(wr_ready), 1);
    tick(); wr_valid = 1'b0; #2;
    check("p2_count", 32'(count), 4);
    check("p2_waddr_wrap", 32'(buf_waddr), 0);
    check("p2_rd_valid", 32'(rd_valid), 1);
    check("p2_wr_ready_full", 32'(wr_ready), 0);
    check("p2_wen_idle", 32'(buf_wen), 0);

    // Two pops slide the window
    rd_ready = 1'b1; #2;
    check("r0_raddr", 32'(buf_raddr), 0);
    tick(); #2;
    check("r1_count", 32'(count), 3);
    check("r1_raddr", 32'(buf_raddr), 1);
    check("r1_rd_valid", 32'(rd_valid), 1);
    check("r1_wr_ready", 32'(wr_ready), 0);
    tick(); rd_ready = 1'b0; #2;
    check("r2_count", 32'(count), 2);
    check("r2_raddr", 32'(buf_raddr), 2);
    check("r2_rd_valid_short", 32'(rd_valid), 0);
    check("r2_wr_ready", 32'(wr_ready), 1);

    // Last push, drain, done pulse
    wr_valid = 1'b1; wr_last = 1'b1; #2;
    check("l_wen", 32'(buf_wen), 1);
    tick(); wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b1; #2;
    check("d0_count", 32'(count), 4);
    check("d0_waddr", 32'(buf_waddr), 2);
    check("d0_wr_ready", 32'(wr_ready), 0);
    check("d0_rd_valid", 32'(rd_valid), 1);
    check("d0_done", 32'(done), 0);
    tick(); #2;
    check("d1_count", 32'(count), 3);
    check("d1_raddr", 32'(buf_raddr), 3);
    check("d1_rd_valid", 32'(rd_valid), 1);
    tick(); #2;
    check("d2_count", 32'(count), 2);
    check("d2_raddr_wrap", 32'(buf_raddr), 0);
    check("d2_rd_valid", 32'(rd_valid), 0);
    check("d2_done", 32'(done), 0);
    tick(); #2;
    check("dn_done", 32'(done), 1);
    check("dn_count", 32'(count), 2);
    check("dn_wr_ready", 32'(wr_ready), 0);
    check("dn_rd_valid", 32'(rd_valid), 0);
    tick(); rd_ready = 1'b0; #2;
    check("post_done", 32'(done), 0);
    check("post_count", 32'(count), 0);
    check("post_waddr", 32'(buf_waddr), 0);
    check("post_raddr", 32'(buf_raddr), 0);
    check("post_wr_ready", 32'(wr_ready), 1);

    // Flush at count=3 with push and pop requested
    wr_valid = 1'b1;
    tick(); tick(); wr_valid = 1'b0; rd_ready = 1'b1;
    tick(); rd_ready = 1'b0; #2;
    check("f_pre_count", 32'(count), 3);
    check("f_pre_raddr", 32'(buf_raddr), 1);
    flush = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1; #2;
    check("f_wen", 32'(buf_wen), 0);
    tick(); flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; #2;
    check("f_count", 32'(count), 0);
    check("f_waddr", 32'(buf_waddr), 0);
    check("f_raddr", 32'(buf_raddr), 0);
    check("f_rd_valid", 32'(rd_valid), 0);

    // 6-deep: simultaneous push and pop at count=3
    v6 = 1'b1;
    tick(); tick(); v6 = 1'b0; #2;
    check("m6_count4", 32'(c6), 4);
    check("m6_waddr4", 32'(wa6), 4);
    check("m6_rd_valid", 32'(rv6), 1);
    rr6 = 1'b1;
    tick(); #2;
    check("m6_count3", 32'(c6), 3);
    check("m6_raddr1", 32'(ra6), 1);
    check("m6_wr_ready", 32'(wrr6), 1);
    v6 = 1'b1; #2;
    check("pp_wen", 32'(wen6), 1);
    check("pp_waddr", 32'(wa6), 4);
    tick(); v6 = 1'b0; rr6 = 1'b0; #2;
    check("pp_count", 32'(c6), 4);
    check("pp_waddr_wrap6", 32'(wa6), 0);
    check("pp_raddr", 32'(ra6), 2);

    // 6-deep: flush while a push would otherwise be accepted
    rr6 = 1'b1;
    tick(); rr6 = 1'b0; #2;
    check("f6_pre_count", 32'(c6), 3);
    check("f6_pre_raddr", 32'(ra6), 3);
    f6 = 1'b1; v6 = 1'b1; rr6 = 1'b1; #2;
    check("f6_wr_ready", 32'(wrr6), 1);
    check("f6_wen", 32'(wen6), 0);
    tick(); f6 = 1'b0; v6 = 1'b0; rr6 = 1'b0; #2;
    check("f6_count", 32'(c6), 0);
    check("f6_waddr", 32'(wa6), 0);
    check("f6_raddr", 32'(ra6), 0);
    check("f6_rd_valid", 32'(rv6), 0);
    check("f6_wr_ready_after", 32'(wrr6), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
